wire_frame_rx: RTL and testbench

//  Serial frame receiver at the far end of the delayed board wire. It recovers

---
 rtl/wire_frame_rx.sv | 145 ++++++++++++++
 tb/tb_wire_frame_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wire_frame_rx.sv
// wire_frame_rx: oversampling serial frame receiver for the delayed board wire.
// Recovers MSB-first words, checks the stop bit and drops frames that overlap local tx.
module wire_frame_rx #(
   parameter int DATA_W      = 8,
   parameter int BIT_CYCLES  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_line,
   input  logic              tx_busy,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_frame_err,
   output logic              rx_collision,
   output logic              rx_active
);
   localparam int PH_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [PH_W-1:0]  PH_MID   = PH_W'(BIT_CYCLES / 2 - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_ls_d;
   logic                   r_armed;
   logic [PH_W-1:0]        r_phase;
   logic [BIT_W-1:0]       r_bit;
   logic [DATA_W-1:0]      r_shift;
   logic                   r_coll;
   logic                   w_ls;
   logic                   w_rise;
   logic                   w_hit;
   logic                   w_done;
   logic                   w_coll;

   // r_fill marks when ls carries a real line sample rather than reset zeros, so a
   // line already high at reset release is not mistaken for a start edge.
   assign w_ls   = r_sync[SYNC_STAGES-1];
   assign w_rise = w_ls & ~r_ls_d & r_armed;
   assign w_coll = r_coll | tx_busy;
   assign w_done = (r_state == ST_STOP) & w_hit;

   // Line synchroniser, edge-detect history and arming
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_fill  <= '0;
         r_ls_d  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_line};
         r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
         r_ls_d  <= w_ls;
         r_armed <= r_armed | (r_fill[SYNC_STAGES-1] & ~w_ls);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and bit-sample strobe
   always_comb begin
      w_next = r_state;
      w_hit  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) w_next = ST_START;
            else        w_next = ST_IDLE;
         end
         ST_START: begin
            w_hit = (r_phase == PH_MID);
            if (w_hit) w_next = w_ls ? ST_DATA : ST_IDLE;
            else       w_next = ST_START;
         end
         ST_DATA: begin
            w_hit = (r_phase == PH_LAST);
            if (w_hit && (r_bit == BIT_LAST)) w_next = ST_STOP;
            else                              w_next = ST_DATA;
         end
         ST_STOP: begin
            w_hit = (r_phase == PH_LAST);
            if (w_hit) w_next = ST_IDLE;
            else       w_next = ST_STOP;
         end
         default: begin
            w_hit  = 1'b0;
            w_next = ST_IDLE;
         end
      endcase
   end

   // Counters, shift register, collision flag and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase      <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_coll       <= 1'b0;
         rx_valid     <= 1'b0;
         rx_data      <= '0;
         rx_frame_err <= 1'b0;
         rx_collision <= 1'b0;
         rx_active    <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) || w_hit) r_phase <= '0;
         else                               r_phase <= r_phase + PH_W'(1);

         if (r_state == ST_IDLE)                r_bit <= '0;
         else if ((r_state == ST_DATA) && w_hit) r_bit <= r_bit + BIT_W'(1);
         else                                   r_bit <= r_bit;

         if ((r_state == ST_DATA) && w_hit) r_shift <= {r_shift[DATA_W-2:0], w_ls};
         else                               r_shift <= r_shift;

         // Sticky for the frame; IDLE always precedes START so clearing here covers entry
         if (r_state == ST_IDLE) r_coll <= 1'b0;
         else if (tx_busy)       r_coll <= 1'b1;
         else                    r_coll <= r_coll;

         rx_valid     <= w_done & ~w_coll & ~w_ls;
         rx_frame_err <= w_done & ~w_coll & w_ls;
         rx_collision <= w_done & w_coll;
         if (w_done && !w_coll && !w_ls) rx_data <= r_shift;
         else                            rx_data <= rx_data;
         rx_active    <= (w_next != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_wire_frame_rx.sv
// Scoreboard bench for wire_frame_rx: frame stimulus pushes the expected result,
// an independent monitor pops and compares on every result pulse.
module tb_wire_frame_rx;
   localparam int DW  = 8;
   localparam int BC  = 4;
   localparam int SS  = 2;
   // cycles from driving the start bit on rx_line to seeing the result pulse
   localparam int LAT = SS + BC / 2 + (DW + 1) * BC + 1;

   localparam logic [2:0] K_VALID = 3'b001;
   localparam logic [2:0] K_ERR   = 3'b010;
   localparam logic [2:0] K_COLL  = 3'b100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_line = 1'b0;
   logic          tx_busy = 1'b0;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          rx_frame_err;
   logic          rx_collision;
   logic          rx_active;

   typedef struct {
      logic [2:0]    kind;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          sbq[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [DW-1:0] last_good = '0;

   wire_frame_rx #(.DATA_W(DW), .BIT_CYCLES(BC), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .rx_line(rx_line), .tx_busy(tx_busy),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
      .rx_collision(rx_collision), .rx_active(rx_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a result pulse appears
   initial begin
      int   n;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            n = int'(rx_valid) + int'(rx_frame_err) + int'(rx_collision);
            if (n > 1) check("one_pulse", n, 1);
            if (n > 0) begin
               if (sbq.size() == 0) begin
                  check("unexpected_pulse", n, 0);
               end else begin
                  e = sbq.pop_front();
                  check("pulse_kind", {rx_collision, rx_frame_err, rx_valid}, e.kind);
                  check("pulse_cycle", cyc, e.cyc);
                  check("rx_data", rx_data, e.data);
               end
            end
         end
      end
   end

   // Drives one frame starting at a negedge; coll_at<0 means no tx_busy overlap
   task automatic send_frame(input logic [DW-1:0] d, input bit stop_bad,
                             input int coll_at, input int stop_len);
      logic bits [0:DW+1];
      exp_t e;
      bits[0] = 1'b1;
      for (int k = 1; k <= DW; k++) bits[k] = d[DW-k];
      bits[DW+1] = stop_bad;
      e.cyc = cyc + LAT;
      if (coll_at >= 0)  begin e.kind = K_COLL;  e.data = last_good; end
      else if (stop_bad) begin e.kind = K_ERR;   e.data = last_good; end
      else               begin e.kind = K_VALID; e.data = d; last_good = d; end
      sbq.push_back(e);
      for (int t = 0; t < (DW + 1) * BC + stop_len; t++) begin
         rx_line = bits[t / BC];
         tx_busy = (t == coll_at);
         @(negedge clk);
      end
      rx_line = 1'b0;
      tx_busy = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_line = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic count_active(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rx_active) cnt++;
      end
   endtask

   task automatic drain;
      for (int i = 0; i < 200; i++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      check("drain_empty", sbq.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, rx_valid, 1'b0);
      check({tag, "_data"}, rx_data, '0);
      check({tag, "_ferr"}, rx_frame_err, 1'b0);
      check({tag, "_coll"}, rx_collision, 1'b0);
      check({tag, "_active"}, rx_active, 1'b0);
   endtask

   initial begin
      int cnt;
      logic [DW-1:0] d;
      bit sb;
      int ca;
      int sl;
      // reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(6);

      // single good frame, back-to-back pair at minimum gap
      send_frame(8'hFF, 1'b0, -1, BC);
      idle(3);
      send_frame(8'hA5, 1'b0, -1, BC - 1);
      send_frame(8'h5A, 1'b0, -1, BC);
      idle(5);

      // collision mid-DATA, then forced stop-bit error
      send_frame(8'hAA, 1'b0, 5 * BC, BC);
      idle(5);
      send_frame(8'h3C, 1'b1, -1, BC);
      idle(6);

      // one-cycle glitch: two cycles active, no pulse; then a clean frame
      rx_line = 1'b1;
      @(negedge clk);
      rx_line = 1'b0;
      count_active(10, cnt);
      check("glitch_active_cycles", cnt, 2);
      send_frame(8'h81, 1'b0, -1, BC);
      idle(4);

      // stop bit high and line left high: one error, then FSM stays idle
      send_frame(8'h3C, 1'b1, -1, BC);
      rx_line = 1'b1;
      count_active(60, cnt);
      check("stuck_high_active", cnt, 0);
      idle(8);

      // tx_busy while idle must not taint the next frame
      tx_busy = 1'b1;
      idle(5);
      tx_busy = 1'b0;
      idle(8);
      send_frame(8'h66, 1'b0, -1, BC);
      drain();

      // reset in the middle of frame 0xC3 (bit 4)
      d = 8'hC3;
      for (int t = 0; t < 5 * BC + 2; t++) begin
         rx_line = (t < BC) ? 1'b1 : d[DW - (t / BC)];
         @(negedge clk);
      end
      check("midframe_active", rx_active, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      rx_line = 1'b0;
      last_good = '0;
      sbq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      send_frame(8'h0F, 1'b0, -1, BC);
      drain();

      // line already high when reset releases
      rst_n = 1'b0;
      rx_line = 1'b1;
      last_good = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      count_active(30, cnt);
      check("high_at_release_active", cnt, 0);
      idle(4);
      send_frame(8'h99, 1'b0, -1, BC);
      idle(3);

      // randomized frames
      for (int i = 0; i < 30; i++) begin
         d  = DW'($urandom);
         sb = ($urandom_range(0, 5) == 0);
         ca = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2 * BC, 8 * BC)) : -1;
         sl = (!sb && $urandom_range(0, 2) == 0) ? BC - 1 : BC;
         send_frame(d, sb, ca, sl);
         if (sb) idle(int'($urandom_range(1, 6)));
         else    idle(int'($urandom_range(0, 6)));
      end

      drain();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
